// File: rtl/sequenciador_carga_reg_pkg.sv
// Shared definitions for the register-load sequencer.
// - state_t : FSM encodings (IDLE=0, GRANT=1, WRITE=2, ACK=3)
// - DEF_*   : default sizes that the register bank is built with
// - ptr_w() : width of a requester index (at least 1 bit)
package sequenciador_carga_reg_pkg;
  localparam int DEF_N_REQ = 2;
  localparam int DEF_N_REG = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_RW    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sequenciador_carga_reg_if.sv
// Requester/register-bank bus of the load sequencer.
// - Req/Dest/Din : per-requester request, target register, write data
// - Gnt/Done     : one-hot grant and one-cycle completion pulse
// - Op/A         : register load strobes and shared write data bus
// - Busy         : sequencer not idle
// master = requester side, slave = sequencer side.
interface sequenciador_carga_reg_if #(
  parameter int N_REQ = 2,
  parameter int N_REG = 4,
  parameter int W     = 8,
  parameter int RW    = 2
);
  logic [N_REQ-1:0]         Req;
  logic [N_REQ-1:0][RW-1:0] Dest;
  logic [N_REQ-1:0][W-1:0]  Din;
  logic [N_REQ-1:0]         Gnt;
  logic [N_REQ-1:0]         Done;
  logic [N_REG-1:0]         Op;
  logic [W-1:0]             A;
  logic                     Busy;

  modport master (output Req, Dest, Din, input Gnt, Done, Op, A, Busy);
  modport slave  (input Req, Dest, Din, output Gnt, Done, Op, A, Busy);
endinterface

// File: rtl/sequenciador_carga_reg_arbitro_rr.sv
// Combinational round-robin pick (arbitro_rr).
// - req : request vector
// - ptr : highest-priority requester
// - idx : winner, first set bit at or above ptr, wrapping
// - vld : at least one request present
module sequenciador_carga_reg_arbitro_rr
  import sequenciador_carga_reg_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             vld
);
  logic [PW:0]   s;
  logic [PW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    s   = '0;
    j   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(N_REQ)) s = s - (PW+1)'(N_REQ);
      j = s[PW-1:0];
      if (req[j]) begin
        idx = j;
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sequenciador_carga_reg.sv
// Register-load sequencer: arbitrates requesters round-robin and drives
// the load strobes / shared data bus of the register bank, one load per
// write cycle. Sequence IDLE -> GRANT -> WRITE -> ACK -> IDLE.
// - Clk   : rising-edge clock
// - Rst_n : async active-low reset, release synchronised to Clk
// - bus   : slave side of sequenciador_carga_reg_if
module sequenciador_carga_reg
  import sequenciador_carga_reg_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int N_REG = DEF_N_REG,
  parameter int W     = DEF_W,
  parameter int RW    = DEF_RW
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  sequenciador_carga_reg_if.slave  bus
);
  localparam int PW = ptr_w(N_REQ);

  logic [1:0]       rst_sync;
  logic             rst_i;
  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, win, arb_idx;
  logic             arb_vld;
  logic [N_REQ-1:0] gnt, done, arb_oh, win_oh;
  logic [N_REG-1:0] op, dec;
  logic [W-1:0]     a;

  // Assert immediately, release two edges later.
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i = rst_sync[1];

  sequenciador_carga_reg_arbitro_rr #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req(bus.Req), .ptr(ptr), .idx(arb_idx), .vld(arb_vld)
  );

  assign arb_oh = N_REQ'(1) << arb_idx;
  assign win_oh = N_REQ'(1) << win;

  // Out-of-range destinations decode to no strobe at all.
  always_comb begin
    dec = '0;
    for (int r = 0; r < N_REG; r++)
      if (bus.Dest[win] == RW'(r)) dec[r] = 1'b1;
  end

  always_ff @(posedge Clk or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_vld) state_nxt = GRANT;
      GRANT:   state_nxt = bus.Req[win] ? WRITE : IDLE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered on the transition into the state that shows them.
  always_ff @(posedge Clk or negedge rst_i)
    if (!rst_i) begin
      ptr  <= '0;
      win  <= '0;
      gnt  <= '0;
      done <= '0;
      op   <= '0;
      a    <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (arb_vld) begin
          win <= arb_idx;
          gnt <= arb_oh;
        end
        GRANT: if (bus.Req[win]) begin
          op <= dec;
          a  <= bus.Din[win];
        end else begin
          gnt <= '0;            // abort: pointer left untouched
        end
        WRITE: begin
          op   <= '0;
          gnt  <= '0;
          done <= win_oh;
        end
        ACK: ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
        default: ;
      endcase
    end

  assign bus.Gnt  = gnt;
  assign bus.Done = done;
  assign bus.Op   = op;
  assign bus.A    = a;
  assign bus.Busy = (state != IDLE);
endmodule

// File: tb/tb_sequenciador_carga_reg.sv
// Directed bench for sequenciador_carga_reg (N_REQ=2, N_REG=4, W=8).
module tb_sequenciador_carga_reg;
  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  sequenciador_carga_reg_if #(.N_REQ(2), .N_REG(4), .W(8), .RW(2)) bus ();

  sequenciador_carga_reg #(.N_REQ(2), .N_REG(4), .W(8), .RW(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         op3_hits = 0;
  logic       op3_watch = 1'b0;
  logic [1:0] prev_done = '0;
  logic [7:0] regs [4] = '{default: 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // One full transaction; expectations supplied by the caller.
  task automatic write_one(input string tag, input logic [1:0] mask, input int w,
                           input logic [3:0] op_exp, input logic [7:0] a_exp, input bit keep);
    logic [1:0] g;
    g = 2'b01 << w;
    bus.Req = mask;
    step();
    chk({tag, ".gnt"}, bus.Gnt, g);
    chk({tag, ".busy"}, bus.Busy, 1);
    chk({tag, ".op_pre"}, bus.Op, 0);
    step();
    chk({tag, ".op"}, bus.Op, op_exp);
    chk({tag, ".a"}, bus.A, a_exp);
    chk({tag, ".gnt_w"}, bus.Gnt, g);
    step();
    chk({tag, ".done"}, bus.Done, g);
    chk({tag, ".op_ack"}, bus.Op, 0);
    chk({tag, ".gnt_ack"}, bus.Gnt, 0);
    if (!keep) bus.Req = '0;
    step();
    chk({tag, ".idle"}, bus.Busy, 0);
    chk({tag, ".done_off"}, bus.Done, 0);
  endtask

  // Downstream register bank.
  always @(posedge Clk)
    for (int r = 0; r < 4; r++)
      if (bus.Op[r]) regs[r] <= bus.A;

  // Invariants every cycle out of reset.
  always @(negedge Clk)
    if (Rst_n) begin
      chk("inv.op_onehot0", 32'($onehot0(bus.Op)), 1);
      chk("inv.gnt_onehot0", 32'($onehot0(bus.Gnt)), 1);
      chk("inv.done_pulse", 32'((bus.Done != 0) && (prev_done != 0)), 0);
      prev_done <= bus.Done;
      if (op3_watch && bus.Op[3]) op3_hits <= op3_hits + 1;
    end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req  = '0;
    bus.Dest = '0;
    bus.Din  = '0;
    Rst_n    = 1'b0;
    #12;
    chk("rst.gnt", bus.Gnt, 0);
    chk("rst.done", bus.Done, 0);
    chk("rst.op", bus.Op, 0);
    chk("rst.a", bus.A, 0);
    chk("rst.busy", bus.Busy, 0);
    step();
    Rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst.busy", bus.Busy, 0);

    // Single write, requester 0 -> reg 2
    bus.Dest[0] = 2'd2; bus.Din[0] = 8'hA5;
    write_one("single", 2'b01, 0, 4'b0100, 8'hA5, 1'b0);
    chk("single.a_hold", bus.A, 8'hA5);

    // Load reg 3 with 3C via requester 1
    bus.Dest[1] = 2'd3; bus.Din[1] = 8'h3C;
    write_one("load3", 2'b10, 1, 4'b1000, 8'h3C, 1'b0);

    // Contention with Req held high; then a fifth write to reg 2
    op3_watch = 1'b1;
    bus.Dest[0] = 2'd0; bus.Din[0] = 8'h11;
    bus.Dest[1] = 2'd1; bus.Din[1] = 8'h22;
    write_one("cont0", 2'b11, 0, 4'b0001, 8'h11, 1'b1);
    write_one("cont1", 2'b11, 1, 4'b0010, 8'h22, 1'b1);
    write_one("cont2", 2'b11, 0, 4'b0001, 8'h11, 1'b1);
    write_one("cont3", 2'b11, 1, 4'b0010, 8'h22, 1'b0);
    bus.Dest[0] = 2'd2; bus.Din[0] = 8'h77;
    write_one("fifth", 2'b01, 0, 4'b0100, 8'h77, 1'b0);
    op3_watch = 1'b0;
    chk("hold.op3_hits", op3_hits, 0);
    chk("hold.reg3", regs[3], 8'h3C);
    chk("hold.reg0", regs[0], 8'h11);
    chk("hold.reg1", regs[1], 8'h22);
    chk("hold.reg2", regs[2], 8'h77);

    // Abort: requester 1 drops Req during GRANT; pointer stays at 1
    bus.Dest[1] = 2'd1; bus.Din[1] = 8'h99;
    bus.Req = 2'b10;
    step();
    chk("abort.gnt", bus.Gnt, 2'b10);
    chk("abort.busy", bus.Busy, 1);
    bus.Req = 2'b00;
    step();
    chk("abort.gnt_off", bus.Gnt, 0);
    chk("abort.idle", bus.Busy, 0);
    chk("abort.no_op", bus.Op, 0);
    chk("abort.a_kept", bus.A, 8'h77);
    step();
    chk("abort.no_done", bus.Done, 0);
    bus.Dest[0] = 2'd0; bus.Din[0] = 8'h44;
    bus.Dest[1] = 2'd1; bus.Din[1] = 8'h55;
    write_one("abort.rr", 2'b11, 1, 4'b0010, 8'h55, 1'b0);

    // Reset asserted during WRITE
    bus.Dest[0] = 2'd3; bus.Din[0] = 8'hC3;
    bus.Req = 2'b01;
    step();
    chk("rstw.gnt", bus.Gnt, 2'b01);
    step();
    chk("rstw.op", bus.Op, 4'b1000);
    chk("rstw.a", bus.A, 8'hC3);
    #1 Rst_n = 1'b0;
    #1;
    chk("rstw.op0", bus.Op, 0);
    chk("rstw.gnt0", bus.Gnt, 0);
    chk("rstw.done0", bus.Done, 0);
    chk("rstw.a0", bus.A, 0);
    chk("rstw.busy0", bus.Busy, 0);
    bus.Req = 2'b00;
    step(); step();
    chk("rstw.reg3_hold", regs[3], 8'h3C);
    Rst_n = 1'b1;
    step(); step(); step();
    chk("rstw.idle", bus.Busy, 0);

    // Pointer back at 0 after reset
    bus.Dest[0] = 2'd0; bus.Din[0] = 8'h5A;
    bus.Dest[1] = 2'd1; bus.Din[1] = 8'h66;
    write_one("post_rst", 2'b11, 0, 4'b0001, 8'h5A, 1'b0);
    chk("post_rst.reg0", regs[0], 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
